muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the MIPS pipeline EX stage.
- Replaces the single-cycle `{hi,lo} <= A*B` path with an iterative shift-add multiplier and a restoring divider.
- Exposes a start/busy/done handshake and generates the pipeline stall for MFHI/MFLO and for back-to-back MULT/DIV.

---
 rtl/muldiv_ctrl.sv | 174 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO, with start/busy/done handshake and stall.
// Optional MULDIV_FAST_MUL_EN: single-step multiply through a hardware multiplier.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StAdj} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;

    logic                 sgn_a, sgn_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, rem_sh, rem_sub;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_neg;
    logic [WIDTH-1:0]     quot_neg, rem_neg;

    assign sgn_a = op[0] & a[WIDTH-1];
    assign sgn_b = op[0] & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    // Multiply: prod holds {acc, multiplier}; add multiplicand on LSB, then shift right.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Divide: prod holds {rem, quot}; shift left, trial-subtract the divisor.
    assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub  = rem_sh - {1'b0, opb_q};
    assign rem_ge   = rem_sh >= {1'b0, opb_q};
    assign div_next = rem_ge ? {rem_sub[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    assign prod_neg = -prod_q;
    assign quot_neg = -prod_q[WIDTH-1:0];
    assign rem_neg  = -prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !kill) begin
                    is_div_d = op[1];
                    neg_a_d  = sgn_a;
                    neg_b_d  = sgn_b;
                    dz_d     = 1'b0;
                    cnt_d    = CntW'(WIDTH - 1);
                    if (op[1]) begin
                        if (b == '0) begin
                            prod_d  = {a, {WIDTH{1'b1}}};
                            dz_d    = 1'b1;
                            state_d = StAdj;
                        end else begin
                            prod_d  = {{WIDTH{1'b0}}, mag_a};
                            opb_d   = mag_b;
                            state_d = StCalc;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        prod_d  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                        opb_d   = mag_a;
                        state_d = StAdj;
`else
                        prod_d  = {{WIDTH{1'b0}}, mag_b};
                        opb_d   = mag_a;
                        state_d = StCalc;
`endif
                    end
                end
            end
            StCalc: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    prod_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = StAdj;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StAdj: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    if (dz_q) begin
                        {hi_d, lo_d} = prod_q;
                    end else if (is_div_q) begin
                        lo_d = (neg_a_q ^ neg_b_q) ? quot_neg : prod_q[WIDTH-1:0];
                        hi_d = neg_a_q ? rem_neg : prod_q[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod_q;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign stall   = busy & (rd_en | start);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (WIDTH=32); honours MULDIV_FAST_MUL_EN if defined.
module tb_muldiv_ctrl;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, kill, rd_en, rd_sel;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] rd_data, hi, lo;
    logic        busy, done, stall;

    int checks = 0;
    int failures = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .kill    (kill),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from the first busy cycle until done shows, bounded at 200.
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        lat = lat - 1;
    endtask

    int lat, bc, sc;
    bit seen;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        rd_en = 1'b0;
        rd_sel = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        #2;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", {31'b0, done}, 32'h0);

        issue(MULTU, 32'hFFFF_FFFF, 32'h2);
        check("multu_busy_c1", {31'b0, busy}, 32'h1);
        wait_done(lat, bc);
        check("multu_lat", lat, MUL_LAT);
        check("multu_busy_cycles", bc, MUL_LAT);
        check("multu_busy_at_done", {31'b0, busy}, 32'h0);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        tick();
        check("done_one_pulse", {31'b0, done}, 32'h0);

        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        check("div_lat", lat, DIV_LAT);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // Read and start together in IDLE: old HI returned, no stall.
        rd_en = 1'b1;
        rd_sel = 1'b0;
        op = DIVU;
        a = 32'd7;
        b = 32'd2;
        start = 1'b1;
        #1;
        check("idle_rd_stall", {31'b0, stall}, 32'h0);
        check("idle_rd_data", rd_data, 32'hFFFF_FFFF);
        tick();
        start = 1'b0;
        rd_en = 1'b0;
        wait_done(lat, bc);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(DIVU, 32'd5, 32'd0);
        wait_done(lat, bc);
        check("div0_lat", lat, 1);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        // MFLO stalls behind a MULTU; a second start held through busy lands after done.
        op = MULTU;
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        tick();
        rd_en = 1'b1;
        rd_sel = 1'b1;
        op = DIVU;
        a = 32'd7;
        b = 32'd2;
        lat = 1;
        sc = 0;
        while (!done && lat < 200) begin
            if (stall) sc++;
            tick();
            lat++;
        end
        check("stall_lat", lat - 1, MUL_LAT);
        check("stall_cycles", sc, MUL_LAT);
        check("stall_at_done", {31'b0, stall}, 32'h0);
        check("stall_rd_data", rd_data, 32'd15);
        tick();
        start = 1'b0;
        rd_en = 1'b0;
        check("second_start_busy", {31'b0, busy}, 32'h1);
        wait_done(lat, bc);
        check("second_lo", lo, 32'd3);
        check("second_hi", hi, 32'd1);

        // Kill a DIVU at cycle 10.
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'h0);
        check("kill_done", {31'b0, done}, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("kill_no_done", {31'b0, seen}, 32'h0);
        check("kill_hi", hi, 32'd1);
        check("kill_lo", lo, 32'd3);

        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check("mult_m1_lat", lat, MUL_LAT);
        check("mult_m1_hi", hi, 32'h0);
        check("mult_m1_lo", lo, 32'h1);

        // Asynchronous reset at cycle 20 of a MULT.
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        repeat (19) tick();
        rd_en = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_done", {31'b0, done}, 32'h0);
        check("arst_stall", {31'b0, stall}, 32'h0);
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_post_done", {31'b0, done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
